// File: rtl/seg_number_display_if.sv
// Request/result bundle between a board top and seg_number_display.
// master drives the conversion request; slave is the display driver.
interface seg_number_display_if #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) ();
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  signed_mode;
  logic [7*DIGITS-1:0]   seg;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (output start, value, signed_mode,
                  input  seg, busy, done, overflow);
  modport slave  (input  start, value, signed_mode,
                  output seg, busy, done, overflow);
endinterface

// File: rtl/seg_number_display.sv
// Sequential binary-to-decimal seven-segment driver: one double-dabble
// shift per clock, then a single registered update of all digit patterns.
// Optional build macro SEG_BLANK_EN: blank leading zero magnitude digits.

// Single digit pattern: active-low g..a, dash wins over blank over numeral.
module seg_number_display_digit (
  input  logic [3:0] nibble,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg7
);
  // Pattern select
  always_comb begin
    seg7 = 7'h7F;
    if (dash)       seg7 = 7'h3F;
    else if (blank) seg7 = 7'h7F;
    else begin
      case (nibble)
        4'd0: seg7 = 7'h40;
        4'd1: seg7 = 7'h79;
        4'd2: seg7 = 7'h24;
        4'd3: seg7 = 7'h30;
        4'd4: seg7 = 7'h19;
        4'd5: seg7 = 7'h12;
        4'd6: seg7 = 7'h02;
        4'd7: seg7 = 7'h78;
        4'd8: seg7 = 7'h00;
        4'd9: seg7 = 7'h10;
        default: seg7 = 7'h3F;
      endcase
    end
  end
endmodule

module seg_number_display #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  seg_number_display_if.slave bus
);
  localparam int MW = WIDTH + 1;          // magnitude incl. -2^(W-1)
  localparam int BW = 4 * DIGITS;         // BCD accumulator
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SEG_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CONV, FORMAT} state_t;

  state_t              state;
  logic [BW-1:0]       bcd;
  logic [MW-1:0]       mag;
  logic [CW-1:0]       cnt;
  logic                sm_q, neg_q, carry;
  logic [7*DIGITS-1:0] seg_q;
  logic                busy_q, done_q, ovf_q;

  logic [MW-1:0]       val_ext, mag_in;
  logic [BW-1:0]       bcd_adj;
  logic [DIGITS-1:0]   dash, blank, lz;
  logic [7*DIGITS-1:0] seg_next;
  logic                ovf_next, hi_nz, seen;
  int                  m_lim;

  assign bus.seg      = seg_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

  // Magnitude of the incoming value (sign-extended before negation)
  always_comb begin
    val_ext = {bus.value[WIDTH-1], bus.value};
    mag_in  = (bus.signed_mode && bus.value[WIDTH-1]) ? -val_ext
                                                      : {1'b0, bus.value};
  end

  // Per-digit add-3 correction and pattern decode
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                        : bcd[4*i +: 4];
    seg_number_display_digit u_dig (
      .nibble (bcd[4*i +: 4]),
      .dash   (dash[i]),
      .blank  (blank[i]),
      .seg7   (seg_next[7*i +: 7])
    );
  end

  // Overflow, sign position and leading-zero classification of final BCD
  always_comb begin
    m_lim = sm_q ? DIGITS - 1 : DIGITS;
    hi_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (i >= m_lim && bcd[4*i +: 4] != 4'd0) hi_nz = 1'b1;
    ovf_next = carry | hi_nz;
    // lz[i]: every magnitude nibble from i upward is zero
    seen = 1'b0;
    lz   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i < m_lim && bcd[4*i +: 4] != 4'd0) seen = 1'b1;
      lz[i] = !seen;
    end
    dash  = '0;
    blank = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_next)
        dash[i] = 1'b1;
      else if (sm_q && i == DIGITS - 1) begin
        dash[i]  = neg_q;
        blank[i] = !neg_q;
      end else
        blank[i] = BLANK_EN && i > 0 && lz[i];
    end
  end

  // Control FSM: capture, WIDTH+1 shifts, one registered format cycle
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state  <= IDLE;
      bcd    <= '0;
      mag    <= '0;
      cnt    <= '0;
      sm_q   <= 1'b0;
      neg_q  <= 1'b0;
      carry  <= 1'b0;
      seg_q  <= '1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          sm_q   <= bus.signed_mode;
          neg_q  <= bus.signed_mode & bus.value[WIDTH-1];
          mag    <= mag_in;
          bcd    <= '0;
          carry  <= 1'b0;
          cnt    <= '0;
          busy_q <= 1'b1;
          state  <= CONV;
        end
        CONV: begin
          bcd   <= {bcd_adj[BW-2:0], mag[MW-1]};
          mag   <= {mag[MW-2:0], 1'b0};
          carry <= carry | bcd_adj[BW-1];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH)) state <= FORMAT;
        end
        FORMAT: begin
          seg_q  <= seg_next;
          ovf_q  <= ovf_next;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/seg_number_display.md
# seg_number_display

Sequential signed/unsigned binary-to-decimal display driver for the board's seven-segment banks. It accepts a WIDTH-bit value on a start strobe and converts it with one double-dabble shift per clock. It then registers DIGITS active-low segment patterns, with a sign position, overflow indication and optional leading-zero blanking. It replaces the per-digit combinational shift-add-three plus decoder chains in board tops, and drives HEX outputs directly.

## Interface
- WIDTH, 10: input value width in bits (≥ 2).
- DIGITS, 4: number of seven-segment positions driven (≥ 2).
- CLOCK_50  in  1: system clock; all state changes on rising edge.
- reset  in  1: synchronous, active-high reset.
- start  in  1: request a conversion of `value`; sampled only while busy = 0.
- value  in  WIDTH: binary input, captured on accepted start.
- signed_mode  in  1: captured with value; 1 = two's complement, 0 = unsigned.
- seg  out  7*DIGITS: active-low segments; seg[7i+6:7i] is digit i (0 = rightmost); bit order g..a (bit 6 = g).
- busy  out  1: conversion in progress.
- done  out  1: one-cycle pulse, seg/overflow updated this cycle.
- overflow  out  1: last converted magnitude did not fit; held until next done.

## Operation
- States: IDLE, CONV, FORMAT.
- IDLE: start = 1 → capture value and signed_mode, compute magnitude, clear BCD accumulator, shift counter = 0, go to CONV.
- Magnitude: WIDTH+1 bits. If signed_mode and value[WIDTH-1] = 1, magnitude = -value (sign-extended) and neg = 1. Otherwise magnitude = value and neg = 0. Most negative value (e.g. -512 at WIDTH=10) yields magnitude 512.
- CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, magnitude} left by one. After WIDTH+1 shifts go to FORMAT.
  - BCD accumulator is 4*DIGITS bits.
  - Bits shifted out of the top nibble set an internal carry flag.
- Available magnitude digits: M = DIGITS-1 when signed_mode, else DIGITS.
- FORMAT: overflow = carry flag OR any nonzero nibble at index ≥ M. Register seg, pulse done, return to IDLE.
- Digit patterns: 0–9 standard active-low (0 = 7'h40, 1 = 7'h79, …, 9 = 7'h10); blank = 7'h7F; dash = 7'h3F.
- Normal display: digits 0..M-1 show BCD nibbles.
  - In signed_mode, digit DIGITS-1 shows dash if neg, blank otherwise.
- Overflow display: all DIGITS positions show dash.
- start while busy = 1 is ignored (not queued).
- signed_mode changes after capture have no effect on the running conversion.

## Timing
- Reset values: seg = all 7'h7F (blank), busy = 0, done = 0, overflow = 0, state = IDLE.
- Start sampled at edge k:
  - busy = 1 from edge k to edge k+WIDTH+2.
  - CONV occupies edges k+1..k+WIDTH+1.
  - FORMAT at edge k+WIDTH+2 updates seg and overflow and sets done = 1 for exactly one cycle; busy = 0 in that same cycle.
- Latency: WIDTH+2 cycles from accepted start to done.
- Back-to-back: start held high → new conversion accepted on the edge after done, so throughput is one result per WIDTH+3 cycles.
- seg and overflow hold their previous values throughout CONV; no intermediate values ever appear.
- Reset mid-conversion: abort, state IDLE, seg blanked, no done pulse.
- Reset and start in the same cycle: reset wins.

## Configuration
- SEG_BLANK_EN defined: in normal display, magnitude digits above the most significant nonzero digit show blank instead of 0. Digit 0 always shows a numeral, so value 0 displays "0". The sign position is unaffected.
- SEG_BLANK_EN undefined: all M magnitude digits display numerals, including leading zeros.
- Overflow display and all timing are identical in both builds.

## Test plan
- Reset, then idle 5 cycles → seg = 28'hFFFFFFF, busy = 0, done = 0, overflow = 0.
- Unsigned: signed_mode = 0, value = 1023, start → done exactly 12 cycles later. Digits 3..0 = 7'h79, 7'h40, 7'h24, 7'h30 ("1023"); overflow = 0.
- Signed negative: signed_mode = 1, value = 10'h3F6 (-10). Without SEG_BLANK_EN → digits "-010" (7'h3F, 7'h40, 7'h79, 7'h40). With SEG_BLANK_EN → "- 10", i.e. digit 2 = 7'h7F.
- Signed extremes: value = -512 → "-512", overflow = 0. Repeat at DIGITS = 3 → all digits 7'h3F, overflow = 1.
- Handshake: pulse start, then reassert start every cycle while busy with different values → only the first value is displayed. Exactly one done pulse occurs per accepted start, and seg is unchanged before done.
- Abort: start with value = 5, assert reset 4 cycles later → no done, seg all 7'h7F. A following start with value = 7 produces "7" after 12 cycles.
